// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP           = 32'd4;
  localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc_sel.sv
// Picks the address driven to instruction memory this cycle and the
// pc/req_pc values to load on the next edge (redirect > stall > sequential).
module fetch_next_pc_sel
  import fetch_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  fetch_state_e      state,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] req_pc_next,
  output logic              load_en
);

  logic [ADDR_W-1:0] target_aligned;

  assign target_aligned = {redirect_target[ADDR_W-1:2], 2'b00};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    imem_addr   = req_pc;
    pc_next     = pc;
    req_pc_next = req_pc;
    load_en     = 1'b0;

    if (state == RUN) begin
      if (redirect_valid) begin
        imem_addr   = target_aligned;
        req_pc_next = target_aligned;
        pc_next     = target_aligned + PC_STEP;
        load_en     = 1'b1;
      end else if (!stall) begin
        imem_addr   = pc;
        req_pc_next = pc;
        pc_next     = pc + PC_STEP;
        load_en     = 1'b1;
      end
      // Stalled: re-read req_pc so the memory output stays on the same word.
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, tags the word returned one cycle
// after its address with that address, and applies stall/redirect/halt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              req_valid;
  fetch_state_e      state;

  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] req_pc_next;
  logic              load_en;
  logic              accept;

  fetch_next_pc_sel u_sel (
    .pc              (pc),
    .req_pc          (req_pc),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .state           (state),
    .imem_addr       (imem_addr),
    .pc_next         (pc_next),
    .req_pc_next     (req_pc_next),
    .load_en         (load_en)
  );

  // A redirect squashes whatever word is returning this cycle.
  assign if_valid    = req_valid && (state == RUN) && !redirect_valid;
  assign if_instr    = imem_instr;
  assign if_pc       = req_pc;
  assign if_pc_plus4 = req_pc + PC_STEP;
  assign halted      = (state == HALTED);
  assign accept      = if_valid && !stall;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // register sees the pre-edge values regardless of statement order.
    if (reset) begin
      pc           <= RESET_PC;
      req_pc       <= RESET_PC;
      req_valid    <= 1'b0;
      state        <= RUN;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else if (state == RUN) begin
      if (load_en) begin
        pc        <= pc_next;
        req_pc    <= req_pc_next;
        req_valid <= 1'b1;
      end

      if (redirect_valid && (redirect_target[1:0] != 2'b00))
        misalign_err <= 1'b1;

      if (accept) begin
        fetch_count <= fetch_count + 32'd1;
        // The halt word itself is counted; fetching stops after it.
        if (if_instr == HALT_WORD) begin
          state     <= HALTED;
          req_valid <= 1'b0;
        end
      end
    end
  end

endmodule
